// File: rtl/music_pkg.sv
// Shared definitions for the music-box playback path (memory stage and note player).
package music_pkg;

    // Player FSM states
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StWait = 3'd2,
        StTone = 3'd3,
        StGap  = 3'd4
    } state_e;

    // Duration field encodings (beats minus one)
    localparam logic [1:0] DUR_1B = 2'b00;
    localparam logic [1:0] DUR_2B = 2'b01;
    localparam logic [1:0] DUR_3B = 2'b10;
    localparam logic [1:0] DUR_4B = 2'b11;

    // A zero half-period marks the end of the song
    localparam int unsigned NOTE_EMPTY = 0;

    localparam int unsigned CLK_HZ = 100_000_000;

    // Half-periods in clk cycles at CLK_HZ, C4 through C5
    localparam int unsigned C4 = 191_113;
    localparam int unsigned D4 = 170_262;
    localparam int unsigned E4 = 151_686;
    localparam int unsigned F4 = 143_172;
    localparam int unsigned G4 = 127_551;
    localparam int unsigned A4 = 113_636;
    localparam int unsigned B4 = 101_239;
    localparam int unsigned C5 = 95_556;

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles its output every `period` enabled cycles.
module tone_divider
    import music_pkg::*;
#(
    parameter int unsigned NOTE_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [NOTE_W-1:0] period,
    output logic              wave
);

    logic [NOTE_W-1:0] half_cnt_q, half_cnt_d;
    logic              wave_q, wave_d;

    // Next state: clr restarts the wave high so every note begins on a rising edge
    always_comb begin
        half_cnt_d = half_cnt_q;
        wave_d     = wave_q;
        if (clr) begin
            half_cnt_d = '0;
            wave_d     = 1'b1;
        end else if (en) begin
            if (half_cnt_q == period - NOTE_W'(1)) begin
                half_cnt_d = '0;
                wave_d     = ~wave_q;
            end else begin
                half_cnt_d = half_cnt_q + NOTE_W'(1);
            end
        end
    end

    // Half-period counter and toggle flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_q <= '0;
            wave_q     <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            wave_q     <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/note_player.sv
// Steps through {note, duration} entries from the memory stage and plays each as a square wave.
module note_player
    import music_pkg::*;
#(
    parameter int unsigned NOTE_W      = 20,
    parameter int unsigned COUNT_W     = 27,
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned LOAD_WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [NOTE_W-1:0] note,
    input  logic [1:0]        duration,
    output logic              playSound,
    output logic              audioOut,
    output logic              busy,
    output logic              songDone
);

    if (64'(BEAT_CYCLES) * 64'd4 >= (64'd1 << COUNT_W)) begin : g_len_overflow
        $error("note_player: 4*BEAT_CYCLES does not fit in COUNT_W bits");
    end
    if (GAP_CYCLES >= BEAT_CYCLES) begin : g_gap_too_long
        $error("note_player: GAP_CYCLES must be smaller than BEAT_CYCLES");
    end
    if (LOAD_WAIT == 0) begin : g_no_load_wait
        $error("note_player: LOAD_WAIT must be at least 1");
    end

    localparam logic [COUNT_W-1:0] BeatLen  = COUNT_W'(BEAT_CYCLES);
    localparam logic [COUNT_W-1:0] GapLen   = COUNT_W'(GAP_CYCLES);
    localparam logic [COUNT_W-1:0] GapLast  = COUNT_W'(GAP_CYCLES - 1);
    localparam logic [COUNT_W-1:0] WaitLast = COUNT_W'(LOAD_WAIT - 1);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [1:0]         dur_q, dur_d;
    logic               play_q, play_d;
    logic               busy_q, busy_d;
    logic               clr;
    logic               song_done;
    logic               wave;
    logic [COUNT_W-1:0] tone_last;

    // Audible part of the note; the articulation gap is carved out of the last beat
    assign tone_last = (COUNT_W'(dur_q) + COUNT_W'(1)) * BeatLen - GapLen - COUNT_W'(1);

    // Next-state logic: stop beats start beats the normal sequence, in every state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        note_d    = note_q;
        dur_d     = dur_q;
        clr       = 1'b0;
        song_done = 1'b0;
        if (stop) begin
            state_d = StIdle;
            cnt_d   = '0;
            clr     = 1'b1;
        end else if (start) begin
            state_d = StReq;
            cnt_d   = '0;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StReq: begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
                StWait: begin
                    if (cnt_q == WaitLast) begin
                        note_d = note;
                        dur_d  = duration;
                        cnt_d  = '0;
                        if (note == NOTE_W'(NOTE_EMPTY)) begin
                            song_done = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            state_d = StTone;
                            clr     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                end
                StTone: begin
                    if (cnt_q == tone_last) begin
                        cnt_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? StReq : StGap;
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_d   = '0;
                        state_d = StReq;
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
        play_d = (state_d == StReq);
        busy_d = (state_d != StIdle);
    end

    // FSM state, length counter, latched note and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            play_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            play_q  <= play_d;
            busy_q  <= busy_d;
        end
    end

    tone_divider #(
        .NOTE_W (NOTE_W)
    ) u_tone_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == StTone),
        .clr    (clr),
        .period (note_q),
        .wave   (wave)
    );

    assign playSound = play_q;
    assign busy      = busy_q;
    // songDone must coincide with the sampling cycle, so it is decoded rather than registered
    assign songDone  = song_done;
    assign audioOut  = wave & (state_q == StTone);

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: memory stage modelled here, expected traces built from the note timing rules.
module tb_note_player;

    localparam int Beat  = 20;
    localparam int Gap   = 4;
    localparam int LWait = 2;
    localparam int MaxC  = 512;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [19:0] note;
    logic [1:0]  duration;
    logic        playSound, audioOut, busy, songDone;

    int checks = 0;
    int errors = 0;

    // Song memory and its read pointer
    int song_note[16];
    int song_dur[16];
    int cur = 0;
    int nxt = 0;

    // Expected per-cycle outputs
    bit exp_play[MaxC];
    bit exp_audio[MaxC];
    bit exp_busy[MaxC];
    bit exp_done[MaxC];

    always #5 clk = ~clk;

    note_player #(
        .NOTE_W      (20),
        .COUNT_W     (27),
        .BEAT_CYCLES (Beat),
        .GAP_CYCLES  (Gap),
        .LOAD_WAIT   (LWait)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .note      (note),
        .duration  (duration),
        .playSound (playSound),
        .audioOut  (audioOut),
        .busy      (busy),
        .songDone  (songDone)
    );

    // Memory stage: start rewinds, playSound presents the next entry
    always @(posedge clk) begin
        if (start) begin
            nxt <= 0;
        end else if (playSound && nxt < 15) begin
            cur <= nxt;
            nxt <= nxt + 1;
        end
    end

    assign note     = 20'(song_note[cur]);
    assign duration = 2'(song_dur[cur]);

    task automatic clear_song();
        for (int i = 0; i < 16; i++) begin
            song_note[i] = 0;
            song_dur[i]  = 0;
        end
    endtask

    task automatic kill(input int t0);
        for (int c = t0 + 1; c < MaxC; c++) begin
            exp_play[c]  = 1'b0;
            exp_audio[c] = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_done[c]  = 1'b0;
        end
    endtask

    // Expected trace for a song started by a start pulse seen in cycle t0
    task automatic plan(input int t0, output int last);
        int p, idx, n, d, len, ts;
        kill(t0);
        p    = t0 + 1;
        idx  = 0;
        last = t0;
        while (p < MaxC - 3 && idx < 16) begin
            n = song_note[idx];
            d = song_dur[idx];
            exp_play[p] = 1'b1;
            if (n == 0) begin
                for (int c = p; c <= p + LWait; c++) exp_busy[c] = 1'b1;
                exp_done[p + LWait] = 1'b1;
                last = p + LWait;
                break;
            end
            len = (d + 1) * Beat - Gap;
            ts  = p + 1 + LWait;
            for (int t = 0; t < len; t++) begin
                if (ts + t < MaxC) exp_audio[ts + t] = ((t / n) % 2 == 0);
            end
            for (int c = p; c < ts + len + Gap && c < MaxC; c++) exp_busy[c] = 1'b1;
            p    = ts + len + Gap;
            last = p - 1;
            idx++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] obs, want;
        int last;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({playSound, audioOut, busy, songDone} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_init got p/a/b/d=%b want 0000", {playSound, audioOut, busy, songDone});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_song();
        song_note[0] = 5;
        kill(-1);
        plan(0, last);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs  = {playSound, audioOut, busy, songDone};
            want = {exp_play[c], exp_audio[c], exp_busy[c], exp_done[c]};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset_pre cyc %0d got p/a/b/d=%b want %b", c, obs, want);
            end
            start = (c == 0);
        end
        // Mid-tone asynchronous reset, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({playSound, audioOut, busy, songDone} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got p/a/b/d=%b want 0000", {playSound, audioOut, busy, songDone});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {playSound, audioOut, busy, songDone};
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got p/a/b/d=%b want 0000", c, obs);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] obs, want;
        int last;
        do_reset();
        clear_song();
        song_note[0] = 5;
        song_dur[0]  = 0;
        kill(-1);
        plan(0, last);
        for (int c = 0; c < last + 5; c++) begin
            @(negedge clk);
            obs  = {playSound, audioOut, busy, songDone};
            want = {exp_play[c], exp_audio[c], exp_busy[c], exp_done[c]};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL single cyc %0d got p/a/b/d=%b want %b", c, obs, want);
            end
            start = (c == 0);
        end
    endtask

    task automatic test_long_note();
        logic [3:0] obs, want;
        int last;
        do_reset();
        clear_song();
        song_note[0] = 3;
        song_dur[0]  = 3;
        kill(-1);
        plan(0, last);
        for (int c = 0; c < last + 5; c++) begin
            @(negedge clk);
            obs  = {playSound, audioOut, busy, songDone};
            want = {exp_play[c], exp_audio[c], exp_busy[c], exp_done[c]};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL long_note cyc %0d got p/a/b/d=%b want %b", c, obs, want);
            end
            start = (c == 0);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] obs, want;
        int last;
        do_reset();
        clear_song();
        song_note[0] = 7;
        song_dur[0]  = 0;
        song_note[1] = 7;
        song_dur[1]  = 1;
        kill(-1);
        plan(0, last);
        for (int c = 0; c < last + 12; c++) begin
            @(negedge clk);
            obs  = {playSound, audioOut, busy, songDone};
            want = {exp_play[c], exp_audio[c], exp_busy[c], exp_done[c]};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL sequence cyc %0d got p/a/b/d=%b want %b", c, obs, want);
            end
            start = (c == 0);
        end
    endtask

    task automatic test_stop();
        logic [3:0] obs, want;
        int last;
        do_reset();
        clear_song();
        song_note[0] = 6;
        song_dur[0]  = 2;
        kill(-1);
        plan(0, last);
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            obs  = {playSound, audioOut, busy, songDone};
            want = {exp_play[c], exp_audio[c], exp_busy[c], exp_done[c]};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL stop cyc %0d got p/a/b/d=%b want %b", c, obs, want);
            end
            // Memory output changes mid-note must not affect the latched note
            if (c == 8) song_note[0] = 9;
            if (c == 11) song_dur[0] = 0;
            if (c == 13) begin
                song_note[0] = 6;
                song_dur[0]  = 2;
            end
            if (c == 14) kill(14);
            if (c == 25) plan(25, last);
            start = (c == 0) || (c == 25);
            stop  = (c == 14);
        end
        stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, want;
        int last;
        do_reset();
        clear_song();
        song_note[0] = 5;
        song_note[1] = 4;
        kill(-1);
        plan(0, last);
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            obs  = {playSound, audioOut, busy, songDone};
            want = {exp_play[c], exp_audio[c], exp_busy[c], exp_done[c]};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got p/a/b/d=%b want %b", c, obs, want);
            end
            if (c == 21) plan(21, last);
            if (c == 30) kill(30);
            start = (c == 0) || (c == 21) || (c == 30);
            stop  = (c == 30);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] obs, want;
        int last, k;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            clear_song();
            k = int'($urandom_range(1, 3));
            for (int i = 0; i < k; i++) begin
                song_note[i] = int'($urandom_range(1, 8));
                song_dur[i]  = int'($urandom_range(0, 3));
            end
            kill(-1);
            plan(0, last);
            for (int c = 0; c < last + 6; c++) begin
                @(negedge clk);
                obs  = {playSound, audioOut, busy, songDone};
                want = {exp_play[c], exp_audio[c], exp_busy[c], exp_done[c]};
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL random it %0d cyc %0d got p/a/b/d=%b want %b", it, c, obs, want);
                end
                start = (c == 0);
            end
        end
    endtask

    initial begin
        clear_song();
        test_reset();
        test_single();
        test_long_note();
        test_sequence();
        test_stop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
